fsqrt_inv_newton: RTL and testbench
===================================

// Module: fsqrt_inv_newton
// PURPOSE
//  Multi-cycle Newton-Raphson refinement for float32 1/sqrt(x). Sits directly after the 6-bit seed stage.
//  Takes x and the seed y0 from that stage and runs ITER iterations of r' = r*(3 - a*r*r)/2
//  on one shared fixed-point multiplier. Returns a float32 result to the FPU issue logic.
// PARAMETERS
//  ITER  2   Newton iterations, 1..3. Two iterations take the 6-bit seed to 23 bits or more.
//  W     28  fraction bits of the internal Qx.W datapath; operands are W+2 bits wide.
// PORTS
//  clk    in   1   clock; the only clock.
//  rst    in   1   synchronous, active-high reset.
//  x      in   32  float32 operand; sampled on the accepting edge.
//  y0     in   32  float32 seed from the seed stage; sampled on the accepting edge.
//  ready  in   1   request; accepted on a rising edge where ready && !busy.
//  busy   out  1   high from the accepting edge until the edge that raises valid.
//  valid  out  1   one-cycle pulse; y is valid while valid is high.
//  y      out  32  result; holds its value until the next result is written.
// BEHAVIOUR
//  Reset: state=IDLE; busy=0; valid=0; y=32'h0; internal registers cleared.
//    rst also aborts any operation in flight. No valid is produced for an aborted operation.
//  Decode (e = x[30:23], m = x[22:0], k = e-127):
//    if k is even, a = 1.m; if k is odd, a = 2*1.m. a is held as Q2.W.
//    ex_out = 126 - (k >>> 1), an arithmetic shift.
//  Seed alignment (ye = y0[30:23], ym = y0[22:0]):
//    ye == ex_out+1  ->  r0 = 1.ym
//    ye == ex_out    ->  r0 = 0.1ym
//    otherwise       ->  r0 = 0.75
//  FSM states: IDLE, SQ, MA, MR, PACK.
//    IDLE -> SQ on accept.
//    SQ: t = r*r.   MA: u = a*t.   MR: r = r*(3-u) >> 1.
//    MR -> SQ while iterations < ITER; MR -> PACK when the last iteration completes.
//    PACK -> IDLE; PACK writes y and sets valid=1 on the same edge.
//  Products are 2W+4 bits wide; bits [2W+1:W] are kept, i.e. truncated to Q2.W.
//    3-u is computed modulo 2^(W+2).
//  Latency: accepting edge = edge 0. valid and y are registered at edge 3*ITER+1 (edge 7 for ITER=2).
//    The next request can be accepted on the edge after valid, i.e. busy=0 while valid=1.
//  ready while busy is ignored (not queued). ready on the edge valid rises is also ignored.
//  Pack: if r >= 1.0, y = {0, ex_out+1, r[W-1 -: 23]}; else y = {0, ex_out, r[W-2 -: 23]}.
//    A result that is exactly 1.0 therefore packs as exponent ex_out+1 with a zero mantissa.
//  Special cases: decided at accept, still take the full latency, and override PACK.
//    e==0 (zero or denormal, flushed)       -> {x[31], 8'hFF, 23'h0}
//    x NaN                                  -> 32'h7FC00000
//    x[31]==1 with a nonzero, non-NaN value -> 32'h7FC00000
//    x == +inf                              -> 32'h00000000
// CONFIGURATION
//  FSQRT_INV_RNE_EN defined:
//    PACK rounds to nearest-even using the guard bit and the OR of all lower bits.
//    A mantissa carry-out increments the exponent.
//  FSQRT_INV_RNE_EN undefined:
//    PACK truncates (round toward zero). No rounding adder is built.
//  Latency and ports are identical in both configurations.
// TESTING
//  x=32'h3F800000, y0=32'h3F800000 -> y=32'h3F800000; valid at edge 7 (ITER=2).
//  x=32'h40800000, y0=32'h3F000000 -> y=32'h3F000000.
//  x=32'h40000000, y0=32'h3F340000 -> y=32'h3F3504F3 with RNE; within 1 ulp when truncating.
//  Specials:
//    x=32'h00000000 -> 32'h7F800000
//    x=32'hBF800000 -> 32'h7FC00000
//    x=32'h7F800000 -> 32'h00000000
//    each with valid after the same latency.
//  ready held high across back-to-back requests:
//    requests during busy are ignored; exactly one valid pulse per accepted request.
//  Raise rst at edge 3 of an operation:
//    busy=0 and valid=0 on the next edge; no valid pulse follows; a fresh request then completes normally.

Source files
------------

// File: rtl/fsqrt_inv_newton.sv
// fsqrt_inv_newton
//   Multi-cycle Newton-Raphson refinement of float32 1/sqrt(x). Takes the
//   operand x and a coarse seed y0 from the seed stage, runs ITER iterations
//   of r' = r*(3 - a*r*r)/2 on one shared Q2.W multiplier and packs the
//   refined r back into float32.
//
//   Ports
//     clk    clock
//     rst    synchronous active-high reset, also aborts an operation in flight
//     x      float32 operand, sampled on the accepting edge
//     y0     float32 seed, sampled on the accepting edge
//     ready  request, accepted on an edge where ready && !busy
//     busy   high from the accepting edge until the edge that raises valid
//     valid  one-cycle result strobe
//     y      result, held until the next result is written
//
//   Configuration macro
//     FSQRT_INV_RNE_EN  defined: round-to-nearest-even at pack time
//                       undefined: truncate (round toward zero)
module fsqrt_inv_newton #(
   parameter int ITER = 2,
   parameter int W    = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic [31:0] y0,
   input  logic        ready,
   output logic        busy,
   output logic        valid,
   output logic [31:0] y
);

   localparam int DW = W + 2;
   localparam logic [DW-1:0] THREE = {2'b11, {W{1'b0}}};

   typedef enum logic [2:0] {IDLE, SQ, MA, MR, PACK} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] r_q, r_d;
   logic [DW-1:0] acc_q, acc_d;
   logic [7:0]    ex_q, ex_d;
   logic [1:0]    iter_q, iter_d;
   logic          special_q, special_d;
   logic [31:0]   spVal_q, spVal_d;
   logic          valid_q, valid_d;
   logic [31:0]   y_q, y_d;

   // Operand decode: exponent parity decides whether the mantissa is
   // doubled so that the result exponent halves cleanly.
   logic [7:0]        xe, ye, exOut;
   logic [22:0]       xm, ym;
   logic signed [9:0] k, exFull;
   logic [DW-1:0]     aDec, rDec;

   assign xe     = x[30:23];
   assign xm     = x[22:0];
   assign ye     = y0[30:23];
   assign ym     = y0[22:0];
   assign k      = $signed({2'b00, xe}) - 10'sd127;
   assign exFull = 10'sd126 - (k >>> 1);
   assign exOut  = exFull[7:0];
   assign aDec   = k[0] ? {1'b1, xm, {(W-22){1'b0}}} : {2'b01, xm, {(W-23){1'b0}}};

   // Seed alignment: the seed's exponent tells us whether its mantissa sits
   // at 1.x or 0.1x relative to the result exponent; anything else is
   // treated as an unusable seed and replaced by 0.75.
   always_comb begin
      rDec = {4'b0011, {(W-2){1'b0}}};
      if (ye == exOut + 8'd1) begin
         rDec = {2'b01, ym, {(W-23){1'b0}}};
      end else if (ye == exOut) begin
         rDec = {3'b001, ym, {(W-24){1'b0}}};
      end
   end

   // Special operands are resolved at accept time; the datapath still runs
   // so that latency stays constant, and PACK substitutes the stored value.
   logic        spDec;
   logic [31:0] spValDec;

   always_comb begin
      spDec    = 1'b0;
      spValDec = 32'h0;
      if (xe == 8'hFF && xm != 23'h0) begin
         spDec    = 1'b1;
         spValDec = 32'h7FC00000;
      end else if (xe == 8'h00) begin
         spDec    = 1'b1;
         spValDec = {x[31], 8'hFF, 23'h0};
      end else if (x[31]) begin
         spDec    = 1'b1;
         spValDec = 32'h7FC00000;
      end else if (xe == 8'hFF) begin
         spDec    = 1'b1;
         spValDec = 32'h00000000;
      end
   end

   // The single shared multiplier: operands are steered by the FSM state,
   // and the product is truncated back to Q2.W.
   logic [DW-1:0]   mulA, mulB, keep, threeMinusU;
   logic [2*DW-1:0] prod;

   assign threeMinusU = THREE - acc_q;

   always_comb begin
      mulA = r_q;
      mulB = r_q;
      if (state_q == MA) begin
         mulA = a_q;
         mulB = acc_q;
      end else if (state_q == MR) begin
         mulA = r_q;
         mulB = threeMinusU;
      end
   end

   assign prod = {{DW{1'b0}}, mulA} * {{DW{1'b0}}, mulB};
   assign keep = prod[2*W+1:W];

   // Packing: r >= 1.0 means the leading one is at bit W and the exponent
   // goes up by one; otherwise the leading one is at bit W-1.
   logic        rHi;
   logic [22:0] truncMant;
   logic [7:0]  packExp;
   logic [31:0] packWord;

   assign rHi       = |r_q[W+1:W];
   assign truncMant = rHi ? r_q[W-1 -: 23] : r_q[W-2 -: 23];
   assign packExp   = rHi ? ex_q + 8'd1 : ex_q;

`ifdef FSQRT_INV_RNE_EN
   logic        guardBit, stickyBit, roundUp;
   logic [23:0] rounded;

   assign guardBit  = rHi ? r_q[W-24] : r_q[W-25];
   assign stickyBit = rHi ? |r_q[W-25:0] : |r_q[W-26:0];
   assign roundUp   = guardBit & (stickyBit | truncMant[0]);
   assign rounded   = {1'b0, truncMant} + {23'h0, roundUp};
   assign packWord  = {1'b0, packExp + {7'h0, rounded[23]}, rounded[22:0]};
`else
   logic unusedLowBits;

   assign unusedLowBits = ^r_q[W-25:0];
   assign packWord      = {1'b0, packExp, truncMant};
`endif

   logic unusedBits;
   assign unusedBits = ^{prod[2*DW-1:2*W+2], prod[W-1:0], y0[31]};

   // Next-state and datapath control. SQ and MA both write the scratch
   // register (t then u); MR consumes it to update r.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      r_d       = r_q;
      acc_d     = acc_q;
      ex_d      = ex_q;
      iter_d    = iter_q;
      special_d = special_q;
      spVal_d   = spVal_q;
      valid_d   = 1'b0;
      y_d       = y_q;
      case (state_q)
         IDLE: begin
            if (ready) begin
               a_d       = aDec;
               r_d       = rDec;
               acc_d     = '0;
               ex_d      = exOut;
               iter_d    = 2'd0;
               special_d = spDec;
               spVal_d   = spValDec;
               state_d   = SQ;
            end
         end
         SQ: begin
            acc_d   = keep;
            state_d = MA;
         end
         MA: begin
            acc_d   = keep;
            state_d = MR;
         end
         MR: begin
            r_d = keep >> 1;
            if (iter_q == 2'(ITER - 1)) begin
               state_d = PACK;
            end else begin
               iter_d  = iter_q + 2'd1;
               state_d = SQ;
            end
         end
         PACK: begin
            y_d     = special_q ? spVal_q : packWord;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset clears everything and drops any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         r_q       <= '0;
         acc_q     <= '0;
         ex_q      <= 8'h0;
         iter_q    <= 2'd0;
         special_q <= 1'b0;
         spVal_q   <= 32'h0;
         valid_q   <= 1'b0;
         y_q       <= 32'h0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         r_q       <= r_d;
         acc_q     <= acc_d;
         ex_q      <= ex_d;
         iter_q    <= iter_d;
         special_q <= special_d;
         spVal_q   <= spVal_d;
         valid_q   <= valid_d;
         y_q       <= y_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign valid = valid_q;
   assign y     = y_q;

endmodule

// File: tb/tb_fsqrt_inv_newton.sv
// tb_fsqrt_inv_newton
//   Directed-vector bench for fsqrt_inv_newton with hand-computed results.
//   Build with FSQRT_INV_RNE_EN defined to check the rounding configuration.
module tb_fsqrt_inv_newton;

   logic        clk;
   logic        rst;
   logic [31:0] x;
   logic [31:0] y0;
   logic        ready;
   logic        busy;
   logic        valid;
   logic [31:0] y;

   int checkCount = 0;
   int passCount  = 0;

   fsqrt_inv_newton #(.ITER(2), .W(28)) dut (
      .clk   (clk),
      .rst   (rst),
      .x     (x),
      .y0    (y0),
      .ready (ready),
      .busy  (busy),
      .valid (valid),
      .y     (y)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checkCount++;
      if (got === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
      end
   endtask

   // Drives one request, returns the result, the edge number at which valid
   // was seen (edge 0 = accepting edge), busy at that edge, busy just after
   // accept and valid on the following edge.
   task automatic applyStimulus(input logic [31:0] xv, input logic [31:0] yv,
                                output logic [31:0] res, output int lat,
                                output logic busyAtAccept, output logic busyAtValid,
                                output logic validAfter);
      @(negedge clk);
      x     = xv;
      y0    = yv;
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready        = 1'b0;
      busyAtAccept = busy;
      lat          = 99;
      busyAtValid  = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            lat         = i;
            busyAtValid = busy;
            break;
         end
      end
      res = y;
      @(posedge clk);
      #1;
      validAfter = valid;
   endtask

   task automatic runVector(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                            input logic [31:0] expY);
      logic [31:0] res;
      int          lat;
      logic        bAcc, bVal, vAft;
      applyStimulus(xv, yv, res, lat, bAcc, bVal, vAft);
      checkOutput({tag, "_y"}, res, expY);
      checkOutput({tag, "_latency"}, 32'(lat), 32'd7);
      checkOutput({tag, "_busyAfterAccept"}, {31'h0, bAcc}, 32'd1);
      checkOutput({tag, "_busyAtValid"}, {31'h0, bVal}, 32'd0);
      checkOutput({tag, "_validPulse"}, {31'h0, vAft}, 32'd0);
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      logic        bAcc, bVal, vAft;
      int          pulses;

      $display("[TB] starting");
      rst   = 1'b1;
      ready = 1'b0;
      x     = 32'h0;
      y0    = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      checkOutput("reset_busy", {31'h0, busy}, 32'd0);
      checkOutput("reset_valid", {31'h0, valid}, 32'd0);
      checkOutput("reset_y", y, 32'h0);

      // Exact cases: 1/sqrt(1) and 1/sqrt(4)
      runVector("one", 32'h3F800000, 32'h3F800000, 32'h3F800000);
      runVector("four", 32'h40800000, 32'h3F000000, 32'h3F000000);

      // 1/sqrt(2) from a seed that lands on the 0.1ym alignment
      applyStimulus(32'h40000000, 32'h3F340000, res, lat, bAcc, bVal, vAft);
`ifdef FSQRT_INV_RNE_EN
      checkOutput("sqrt2_y", res, 32'h3F3504F3);
`else
      checkOutput("sqrt2_withinUlp", {31'h0, (res == 32'h3F3504F3) || (res == 32'h3F3504F2)}, 32'd1);
`endif
      checkOutput("sqrt2_latency", 32'(lat), 32'd7);

      // Special operands
      runVector("zero", 32'h00000000, 32'h3F800000, 32'h7F800000);
      runVector("negZero", 32'h80000000, 32'h3F800000, 32'hFF800000);
      runVector("negOne", 32'hBF800000, 32'h3F800000, 32'h7FC00000);
      runVector("posInf", 32'h7F800000, 32'h3F800000, 32'h00000000);
      runVector("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);

      // ready held high: one accept every 8 edges, requests while busy
      // and on the valid edge are dropped.
      @(negedge clk);
      x      = 32'h40800000;
      y0     = 32'h3F000000;
      ready  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1;
         if (valid) pulses++;
      end
      ready = 1'b0;
      checkOutput("b2b_pulses", 32'(pulses), 32'd4);
      checkOutput("b2b_lastY", y, 32'h3F000000);
      @(posedge clk);
      #1;
      checkOutput("b2b_idleAfter", {31'h0, busy}, 32'd0);

      // Abort with rst at edge 3 of an operation
      @(negedge clk);
      x     = 32'h3F800000;
      y0    = 32'h3F800000;
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort_busy", {31'h0, busy}, 32'd0);
      checkOutput("abort_valid", {31'h0, valid}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (valid) pulses++;
      end
      checkOutput("abort_noPulse", 32'(pulses), 32'd0);
      checkOutput("abort_yCleared", y, 32'h0);
      runVector("afterAbort", 32'h40800000, 32'h3F000000, 32'h3F000000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
